// File: rtl/counter_ctrl.sv
// Command-driven sequencer for an up/down counter: START/STOP/LOAD/CLEAR over valid/ready.
// Optional checker compiled in with `define COUNTER_CTRL_SVA_EN.
module counter_ctrl #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] DEF_TOP = 8'hFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic             mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Accepted command tagged with a valid bit so "no command" is its own case.
  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_START = 3'b100;
  localparam logic [2:0] C_STOP  = 3'b101;
  localparam logic [2:0] C_LOAD  = 3'b110;
  localparam logic [2:0] C_CLEAR = 3'b111;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             accept_s;
  logic             terminal_s;
  logic [2:0]       cmd_s;

  assign accept_s   = cmd_valid_i && (state_q != ST_LOAD);
  assign terminal_s = dir_q ? (cnt_q == top_q) : (cnt_q == CNT_ZERO);
  assign cmd_s      = accept_s ? {1'b1, cmd_op_i} : C_NONE;

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        case (cmd_s)
          C_START: begin
            cnt_d   = dir_i ? CNT_ZERO : top_q;
            mode_d  = mode_i;
            dir_d   = dir_i;
            state_d = ST_RUN;
          end
          C_STOP:  err_d = 1'b1;
          C_LOAD: begin
            top_d   = cmd_data_i;
            state_d = ST_LOAD;
          end
          C_CLEAR: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
          default: state_d = state_q;
        endcase
      end
      ST_PAUSE: begin
        case (cmd_s)
          C_START: state_d = ST_RUN;
          C_STOP:  err_d = 1'b1;
          C_LOAD: begin
            top_d   = cmd_data_i;
            state_d = ST_LOAD;
          end
          C_CLEAR: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
          default: state_d = state_q;
        endcase
      end
      ST_RUN: begin
        case (cmd_s)
          C_CLEAR: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
          default: begin
            // Illegal commands are flagged but counting carries on untouched.
            err_d = (cmd_s == C_START) || (cmd_s == C_LOAD);
            if (terminal_s) begin
              tick_d = 1'b1;
              if (mode_q) begin
                cnt_d   = dir_q ? CNT_ZERO : top_q;
                state_d = (cmd_s == C_STOP) ? ST_PAUSE : ST_RUN;
              end else begin
                state_d = ST_DONE;
              end
            end else if (cmd_s == C_STOP) begin
              state_d = ST_PAUSE;
            end else begin
              cnt_d = dir_q ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
            end
          end
        endcase
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      top_q   <= DEF_TOP;
      mode_q  <= 1'b0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign tick_o      = tick_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done_o      = (state_q == ST_DONE);
  assign cmd_ready_o = (state_q != ST_LOAD);

`ifdef COUNTER_CTRL_SVA_EN
  counter_ctrl_sva #(.WIDTH(WIDTH)) u_sva (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cnt_i       (cnt_q),
    .busy_i      (busy_o),
    .done_i      (done_o),
    .tick_i      (tick_q),
    .err_i       (err_q),
    .cmd_ready_i (cmd_ready_o),
    .run_i       (state_q == ST_RUN),
    .load_i      (state_q == ST_LOAD),
    .terminal_i  (terminal_s),
    .accept_i    (accept_s),
    .dir_i       (dir_q)
  );
`endif

endmodule

`ifdef COUNTER_CTRL_SVA_EN
module counter_ctrl_sva #(
  parameter int WIDTH = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [WIDTH-1:0] cnt_i,
  input logic             busy_i,
  input logic             done_i,
  input logic             tick_i,
  input logic             err_i,
  input logic             cmd_ready_i,
  input logic             run_i,
  input logic             load_i,
  input logic             terminal_i,
  input logic             accept_i,
  input logic             dir_i
);

  a_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({cnt_i, busy_i, done_i, tick_i, err_i, cmd_ready_i}))
    else $display("%0t counter_ctrl: unknown output", $time);

  a_tick_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    tick_i |=> !tick_i || $past(run_i))
    else $display("%0t counter_ctrl: tick not a single pulse", $time);

  a_step: assert property (@(posedge clk_i) disable iff (rst_i)
    (run_i && !terminal_i && !accept_i) |=>
      ($past(dir_i) ? (cnt_i == $past(cnt_i) + 1'b1) : (cnt_i == $past(cnt_i) - 1'b1)))
    else $display("%0t counter_ctrl: cnt did not step by one", $time);

  a_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    !cmd_ready_i == load_i)
    else $display("%0t counter_ctrl: cmd_ready low outside LOAD", $time);

  a_done_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    done_i |-> !busy_i)
    else $display("%0t counter_ctrl: done with busy", $time);

  c_tick: cover property (@(posedge clk_i) disable iff (rst_i) tick_i);
  c_err:  cover property (@(posedge clk_i) disable iff (rst_i) err_i);
  c_done: cover property (@(posedge clk_i) disable iff (rst_i) done_i);

endmodule
`endif
